layer_seq_ctrl: RTL and testbench
=================================

Name: layer_seq_ctrl

Overview:
- Parametrised layer sequencer for the CNN accelerator. It is the successor to the fixed two-step unshuffle/conv1 controller.
- Walks NUM_STAGES processing stages in order, e.g. unshuffle, conv1, conv2, ..., using a one-hot enable / per-stage done handshake.
- Raises valid once the last stage reports done.
- Sits between the top-level host handshake and the per-layer datapath engines.

Parameters:
- NUM_STAGES, default 4: number of sequenced stages, legal range 1..16.
- IDX_W, default 2: width of stage_idx, equal to $clog2(NUM_STAGES), minimum 1.
- TIMEOUT_W, default 16: width of the per-stage watchdog counter (used only with STAGE_TIMEOUT_EN).
- TIMEOUT_CYC, default 50000: cycles a stage may stay enabled before the watchdog fires (used only with STAGE_TIMEOUT_EN).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  start request; sampled only in IDLE.
- restart  input  1  synchronous abort/clear; returns the block to IDLE from any state.
- stage_done  input  NUM_STAGES  per-stage completion; bit i is examined only while stage i is enabled.
- stage_en  output  NUM_STAGES  one-hot (or zero) stage enable, registered.
- stage_idx  output  IDX_W  index of the current or last-enabled stage, registered.
- busy  output  1  high while in RUN or GAP, registered.
- valid  output  1  high while in DONE, registered.
- err  output  1  high while in ERR, registered; tied 0 without STAGE_TIMEOUT_EN.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, stage_en=0, stage_idx=0, busy=0, valid=0, err=0, watchdog=0.
- All outputs are registered and decoded from next-state, so each output changes on the same edge as the state.
- States: IDLE, RUN, GAP, DONE, ERR.
- IDLE:
  - enable=1 at edge k -> RUN, stage_idx=0, stage_en[0]=1 and busy=1 after edge k.
  - enable=0 -> stay in IDLE.
- RUN:
  - stage_en[stage_idx]=1, all other bits 0.
  - stage_done[stage_idx]=1 at edge m and stage_idx<NUM_STAGES-1 -> GAP. stage_en=0 after edge m.
  - stage_done[stage_idx]=1 at edge m and stage_idx==NUM_STAGES-1 -> DONE. stage_en=0, busy=0, valid=1 after edge m.
  - stage_done bits other than stage_idx are ignored.
- GAP:
  - One mandatory idle cycle so every stage sees a clean rising edge on its enable.
  - Unconditionally -> RUN with stage_idx+1. stage_en[stage_idx+1]=1 after edge m+1.
- DONE:
  - valid held at 1. stage_idx held at NUM_STAGES-1.
  - enable is ignored; the only exit is restart or reset.
- ERR:
  - err held at 1, stage_en=0, busy=0.
  - stage_idx holds the index of the stage that failed.
  - Exit via restart or reset.
- restart=1 in any state: next state IDLE, all outputs return to reset values on that edge. restart takes priority over enable, stage_done and the watchdog.
- enable while not in IDLE: ignored.
- stage_done already high when a stage is entered: that stage completes after exactly one RUN cycle.
- NUM_STAGES=1: IDLE -> RUN -> DONE, with no GAP state ever entered.
- Latency: a stage whose done is high immediately costs 2 cycles (RUN + GAP). The last stage costs 1 cycle.

Optional Feature:
- Macro: STAGE_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_W-bit counter clears on every entry to RUN and increments each RUN cycle.
  - If the counter equals TIMEOUT_CYC-1 and stage_done[stage_idx]=0 -> ERR. err=1 and stage_en=0 after that edge.
  - Done and timeout on the same cycle: done wins.
  - The counter is frozen outside RUN.
- Not defined: no counter, ERR is unreachable, err is constant 0.

Test Plan:
- Reset check: NUM_STAGES=3, assert rst_n low mid-RUN of stage 1 -> stage_en=000, busy=0, valid=0, stage_idx=0 immediately, without waiting for a clock edge.
- Normal run: NUM_STAGES=3, enable pulse at edge 0; each stage_done asserted 5 cycles after its enable rises -> stage_en sequence 001, 000 (1 cycle), 010, 000, 100; valid=1 after the edge sampling stage_done[2]; valid then holds until restart.
- Immediate done: stage_done tied to 111, enable at edge 0 -> stage_en 001@1, 000@2, 010@3, 000@4, 100@5; valid=1 @6.
- Ignore rules: while stage 0 runs, drive stage_done=110 and pulse enable -> no state change; stage_en stays 001.
- Restart priority: in DONE, assert restart and enable together -> IDLE with valid=0 after that edge; stage_en stays 000; a new enable on the following cycle restarts from stage 0.
- Watchdog (STAGE_TIMEOUT_EN, TIMEOUT_CYC=8): hold stage 1 done low -> err=1 and stage_en=000 exactly 8 cycles after stage_en[1] rose, stage_idx=1. Repeat with done asserted on cycle 8 -> no err; sequencing continues.

Source files
------------

// File: rtl/layer_seq_ctrl.sv
// Layer sequencer: walks NUM_STAGES datapath stages with a one-hot enable / done handshake.
// Optional per-stage watchdog enabled by defining STAGE_TIMEOUT_EN.
module layer_seq_ctrl #(
    parameter int NUM_STAGES  = 4,
    parameter int IDX_W       = 2,
    parameter int TIMEOUT_W   = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  restart,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [IDX_W-1:0]      stage_idx,
    output logic                  busy,
    output logic                  valid,
    output logic                  err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        GAP  = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_STAGES - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_W-1:0]        idx_nxt;
    logic [NUM_STAGES-1:0]   en_nxt;
    logic                    done_cur;
    logic                    wd_fire;

    assign done_cur = stage_done[stage_idx];

`ifdef STAGE_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wd;

    assign wd_fire = (wd == TIMEOUT_W'(TIMEOUT_CYC - 1));

    // Cleared on RUN entry, counts RUN cycles, frozen everywhere else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd <= '0;
        end else if (state_nxt == RUN && state != RUN) begin
            wd <= '0;
        end else if (state == RUN) begin
            wd <= wd + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= (state_nxt == ERR);
        end
    end
`else
    assign wd_fire = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        idx_nxt   = stage_idx;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = RUN;
                    idx_nxt   = '0;
                end
            end
            RUN: begin
                // A done on the timeout cycle still counts as success.
                if (done_cur) begin
                    state_nxt = (stage_idx == LAST) ? DONE : GAP;
                end else if (wd_fire) begin
                    state_nxt = ERR;
                end
            end
            GAP: begin
                state_nxt = RUN;
                idx_nxt   = stage_idx + 1'b1;
            end
            DONE: state_nxt = DONE;
            ERR:  state_nxt = ERR;
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
        if (restart) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
        end
    end

    always_comb begin
        en_nxt = '0;
        if (state_nxt == RUN) begin
            en_nxt[idx_nxt] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            stage_idx <= '0;
            stage_en  <= '0;
            busy      <= 1'b0;
            valid     <= 1'b0;
        end else begin
            state     <= state_nxt;
            stage_idx <= idx_nxt;
            stage_en  <= en_nxt;
            busy      <= (state_nxt == RUN) || (state_nxt == GAP);
            valid     <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Bench for layer_seq_ctrl with NUM_STAGES=3; watchdog section active when
// STAGE_TIMEOUT_EN is defined (TIMEOUT_CYC=8).
module tb_layer_seq_ctrl;

    typedef struct {
        logic       en;
        logic       rs;
        logic [2:0] done;
        logic [2:0] x_en;
        logic [1:0] x_idx;
        logic       x_busy;
        logic       x_valid;
        logic       x_err;
        string      name;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       restart;
    logic [2:0] stage_done;
    logic [2:0] stage_en;
    logic [1:0] stage_idx;
    logic       busy;
    logic       valid;
    logic       err;

    int errors = 0;
    int checks = 0;
    vec_t sb[$];
    vec_t tbl[12];

    layer_seq_ctrl #(
        .NUM_STAGES (3),
        .IDX_W      (2),
        .TIMEOUT_W  (16),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .restart   (restart),
        .stage_done(stage_done),
        .stage_en  (stage_en),
        .stage_idx (stage_idx),
        .busy      (busy),
        .valid     (valid),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic en, logic rs, logic [2:0] d,
                                logic [2:0] xe, logic [1:0] xi,
                                logic xb, logic xv, logic xr, string nm);
        vec_t v;
        v.en = en; v.rs = rs; v.done = d;
        v.x_en = xe; v.x_idx = xi; v.x_busy = xb;
        v.x_valid = xv; v.x_err = xr; v.name = nm;
        return v;
    endfunction

    task automatic check_now(vec_t x);
        logic [7:0] got, want;
        got  = {stage_en, stage_idx, busy, valid, err};
        want = {x.x_en, x.x_idx, x.x_busy, x.x_valid, x.x_err};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got en=%b idx=%0d busy=%b valid=%b err=%b, want en=%b idx=%0d busy=%b valid=%b err=%b",
                     x.name, stage_en, stage_idx, busy, valid, err,
                     x.x_en, x.x_idx, x.x_busy, x.x_valid, x.x_err);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(vec_t v);
        vec_t x;
        enable     = v.en;
        restart    = v.rs;
        stage_done = v.done;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", v.name);
        end else begin
            x = sb.pop_front();
            check_now(x);
        end
    endtask

    initial begin
        tbl[0]  = mk(1, 0, 3'b111, 3'b001, 2'd0, 1, 0, 0, "imm_run0");
        tbl[1]  = mk(0, 0, 3'b111, 3'b000, 2'd0, 1, 0, 0, "imm_gap0");
        tbl[2]  = mk(0, 0, 3'b111, 3'b010, 2'd1, 1, 0, 0, "imm_run1");
        tbl[3]  = mk(0, 0, 3'b111, 3'b000, 2'd1, 1, 0, 0, "imm_gap1");
        tbl[4]  = mk(0, 0, 3'b111, 3'b100, 2'd2, 1, 0, 0, "imm_run2");
        tbl[5]  = mk(0, 0, 3'b111, 3'b000, 2'd2, 0, 1, 0, "imm_done");
        tbl[6]  = mk(1, 0, 3'b111, 3'b000, 2'd2, 0, 1, 0, "done_ign_en");
        tbl[7]  = mk(1, 1, 3'b111, 3'b000, 2'd0, 0, 0, 0, "rst_prio");
        tbl[8]  = mk(1, 0, 3'b000, 3'b001, 2'd0, 1, 0, 0, "re_enable");
        tbl[9]  = mk(1, 0, 3'b110, 3'b001, 2'd0, 1, 0, 0, "ignore_bits");
        tbl[10] = mk(0, 0, 3'b001, 3'b000, 2'd0, 1, 0, 0, "gap_after");
        tbl[11] = mk(0, 1, 3'b000, 3'b000, 2'd0, 0, 0, 0, "restart_gap");

        rst_n      = 1'b0;
        enable     = 1'b0;
        restart    = 1'b0;
        stage_done = '0;
        #12;
        check_now(mk(0, 0, 0, 3'b000, 2'd0, 0, 0, 0, "reset_state"));
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step(tbl[i]);
        end

        // Each done arrives 5 cycles after its enable rises.
        step(mk(1, 0, 3'b000, 3'b001, 2'd0, 1, 0, 0, "norm_start"));
        for (int s = 0; s < 3; s++) begin
            logic [2:0] d;
            logic [2:0] oh;
            d  = 3'b001 << s;
            oh = 3'b001 << s;
            for (int c = 0; c < 4; c++) begin
                step(mk(0, 0, ~d, oh, 2'(s), 1, 0, 0, "norm_wait"));
            end
            if (s < 2) begin
                step(mk(0, 0, d, 3'b000, 2'(s), 1, 0, 0, "norm_gap"));
                step(mk(0, 0, 3'b000, oh << 1, 2'(s + 1), 1, 0, 0, "norm_next"));
            end else begin
                step(mk(0, 0, d, 3'b000, 2'd2, 0, 1, 0, "norm_done"));
            end
        end
        for (int c = 0; c < 3; c++) begin
            step(mk(c[0], 0, 3'b000, 3'b000, 2'd2, 0, 1, 0, "norm_hold"));
        end
        step(mk(0, 1, 3'b000, 3'b000, 2'd0, 0, 0, 0, "norm_restart"));

        // Asynchronous reset in the middle of stage 1.
        step(mk(1, 0, 3'b001, 3'b001, 2'd0, 1, 0, 0, "ar_run0"));
        step(mk(0, 0, 3'b001, 3'b000, 2'd0, 1, 0, 0, "ar_gap0"));
        step(mk(0, 0, 3'b000, 3'b010, 2'd1, 1, 0, 0, "ar_run1"));
        #3 rst_n = 1'b0;
        #1 check_now(mk(0, 0, 0, 3'b000, 2'd0, 0, 0, 0, "async_reset"));
        #2 rst_n = 1'b1;

`ifdef STAGE_TIMEOUT_EN
        step(mk(1, 0, 3'b001, 3'b001, 2'd0, 1, 0, 0, "wd_run0"));
        step(mk(0, 0, 3'b001, 3'b000, 2'd0, 1, 0, 0, "wd_gap0"));
        step(mk(0, 0, 3'b000, 3'b010, 2'd1, 1, 0, 0, "wd_run1"));
        for (int c = 1; c < 8; c++) begin
            step(mk(0, 0, 3'b000, 3'b010, 2'd1, 1, 0, 0, "wd_count"));
        end
        step(mk(0, 0, 3'b000, 3'b000, 2'd1, 0, 0, 1, "wd_fire"));
        step(mk(1, 0, 3'b111, 3'b000, 2'd1, 0, 0, 1, "wd_hold"));
        step(mk(0, 1, 3'b000, 3'b000, 2'd0, 0, 0, 0, "wd_restart"));

        step(mk(1, 0, 3'b001, 3'b001, 2'd0, 1, 0, 0, "wd2_run0"));
        step(mk(0, 0, 3'b001, 3'b000, 2'd0, 1, 0, 0, "wd2_gap0"));
        step(mk(0, 0, 3'b000, 3'b010, 2'd1, 1, 0, 0, "wd2_run1"));
        for (int c = 1; c < 8; c++) begin
            step(mk(0, 0, 3'b000, 3'b010, 2'd1, 1, 0, 0, "wd2_count"));
        end
        step(mk(0, 0, 3'b010, 3'b000, 2'd1, 1, 0, 0, "wd2_done_wins"));
        step(mk(0, 0, 3'b000, 3'b100, 2'd2, 1, 0, 0, "wd2_run2"));
        step(mk(0, 0, 3'b100, 3'b000, 2'd2, 0, 1, 0, "wd2_done"));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
